data_sram_responder: RTL and testbench
======================================

Name: data_sram_responder

Overview:
Slave-side model of the CPU's data SRAM port. It sits on the SoC side of data_sram_* and responds to the core's load/store requests with single-cycle synchronous-SRAM semantics. It decodes each request to one of two targets:
- a byte-writable word RAM;
- a small memory-mapped configuration register block (LED, switches, timer, scratch).

The block drives the core's data_sram_rdata. It is used in the SoC top and in the pipeline test bench.

Parameters:
ADDR_W, 12, RAM word-address width (RAM depth = 2^ADDR_W words; default 16 KB)
CONF_BASE, 32'hbfaf_0000, confreg region base; only bits [31:16] are compared
RESET_LED, 16'h0000, LED register value after reset

Ports:
clk  input  1  system clock; all state updates on its rising edge
resetn  input  1  synchronous active-low reset
data_sram_en  input  1  request valid for this cycle
data_sram_we  input  4  byte write enables, lane i = bits [8i+7:8i]; 0 = read
data_sram_addr  input  32  byte address; bits [1:0] ignored (word access)
data_sram_wdata  input  32  write data, lane-aligned
data_sram_rdata  output  32  read data, valid the cycle after the request
led  output  16  LED register
switch  input  8  asynchronous board switches
timer_val  output  32  current timer value (debug)

Behaviour:
Clocking and reset:
- One clock; reset is synchronous and active-low.
- While resetn=0 at an edge:
  - data_sram_rdata <= 0, led <= RESET_LED, timer <= 0, scratch <= 0, both switch sync stages <= 0.
  - Any request in that cycle is ignored: no write, no rdata update.
- RAM contents are not reset.
- Reset asserted in the cycle after a request: the pending rdata is discarded and reads 0.

Decode:
- Confreg hit when data_sram_addr[31:16] == CONF_BASE[31:16]; otherwise RAM.
- RAM index = addr[ADDR_W+1:2]. Higher address bits alias and are not checked.

Read timing:
- At an edge with en=1, rdata <= the selected word's value before that edge (read-first).
- This holds for writes too: a store cycle returns the old word.
- With en=0, rdata holds its previous value indefinitely.
- Back-to-back requests on consecutive cycles are fully pipelined: one response per cycle, latency exactly 1.

Write:
- Occurs when en=1 and we!=0. Each lane with we[i]=1 replaces byte i; other bytes keep their old value.
- A read of the same word in the next cycle returns the merged value.

Confreg map (offset = addr[15:0]):
- 0xE000 TIMER:
  - RW, 32-bit free-running counter, +1 every cycle outside reset, wraps 0xFFFF_FFFF -> 0.
  - A write cycle loads the byte-merged value instead of incrementing; counting resumes on the next cycle.
  - A read returns the pre-edge count.
- 0xF000 LED: RW; lanes 0–1 update led[15:0]; lanes 2–3 ignored; reads as {16'h0, led}.
- 0xF010 SWITCH: RO, {24'h0, sw_sync}. sw_sync is switch passed through a 2-flop synchronizer, so total visible delay is 2 edges. Writes ignored.
- 0xF020 SCRATCH: RW 32-bit, byte-masked.
- Any other confreg offset reads 0; writes have no effect and never reach RAM.

Outputs:
- timer_val mirrors the timer register.
- led mirrors the LED register.

Test Plan:
1. Reset, then store we=4'hF addr=0x1c000100 wdata=0xDEADBEEF; next cycle load same addr → rdata=0xDEADBEEF one cycle after the load's en.
2. Byte merge: word holds 0xDEADBEEF; store we=4'b0101 wdata=0x11223344; then load → 0xDE22BE44. The store cycle itself returns the old word 0xDEADBEEF.
3. Hold/pipeline: loads on addr A, B, C in consecutive cycles, then en=0 for 3 cycles → rdata = A, B, C on successive cycles, then stays at C's value.
4. Timer:
   - Write 0xFFFF_FFFE to 0xbfafe000, then read in the next cycle → 0xFFFF_FFFE.
   - A read one cycle later → 0xFFFF_FFFF.
   - After a further cycle timer_val=0 (wrap).
5. LED/switch:
   - Store we=4'hF wdata=0xABCD1234 to 0xbfaff000 → led=0x1234, read back 0x00001234.
   - Drive switch=0xA5 → a read of 0xbfaff010 issued ≥2 cycles later returns 0x000000A5.
   - A write to 0xbfaff010 leaves it unchanged.
6. Reset mid-operation:
   - Load issued, resetn=0 on the next edge → rdata=0, led=RESET_LED, timer=0.
   - A store during the reset cycle does not modify RAM: a read after release returns the prior contents.
   - An unmapped confreg offset 0xbfaf_0004 reads 0.

Source files
------------

// File: rtl/data_sram_responder.sv
// data_sram_responder: single-cycle SRAM-port slave with a word RAM and a confreg block
module data_sram_responder #(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] CONF_BASE = 32'hbfaf_0000,
    parameter logic [15:0] RESET_LED = 16'h0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [15:0] led,
    input  logic [7:0]  switch,
    output logic [31:0] timer_val
);

    logic [31:0]       ram [2**ADDR_W];
    logic [31:0]       timer;
    logic [31:0]       scratch;
    logic [7:0]        sw_meta;
    logic [7:0]        sw_sync;
    logic [31:0]       mask;
    logic [31:0]       conf_rd;
    logic [31:0]       rd_val;
    logic [15:0]       off;
    logic [ADDR_W-1:0] idx;
    logic              conf_hit;
    logic              wr;
    logic              ram_wr;
    logic              timer_wr;
    logic              led_wr;
    logic              scratch_wr;

    assign off        = data_sram_addr[15:0];
    assign idx        = data_sram_addr[ADDR_W+1:2];
    assign conf_hit   = data_sram_addr[31:16] == CONF_BASE[31:16];
    assign wr         = data_sram_en && (data_sram_we != 4'h0);
    assign ram_wr     = wr && !conf_hit;
    assign timer_wr   = wr && conf_hit && off == 16'he000;
    assign led_wr     = wr && conf_hit && off == 16'hf000;
    assign scratch_wr = wr && conf_hit && off == 16'hf020;
    assign mask       = {{8{data_sram_we[3]}}, {8{data_sram_we[2]}},
                         {8{data_sram_we[1]}}, {8{data_sram_we[0]}}};
    assign timer_val  = timer;

    // Confreg read mux and target select; unmapped offsets read as zero
    always_comb begin
        conf_rd = off == 16'he000 ? timer :
                  off == 16'hf000 ? {16'h0, led} :
                  off == 16'hf010 ? {24'h0, sw_sync} :
                  off == 16'hf020 ? scratch : 32'h0;
        rd_val  = conf_hit ? conf_rd : ram[idx];
    end

    // Byte-lane RAM writes; contents survive reset but writes are blocked during it
    always_ff @(posedge clk) begin
        if (resetn && ram_wr)
            for (int i = 0; i < 4; i++)
                if (data_sram_we[i])
                    ram[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
    end

    // Read-first response register, timer, LED, scratch and switch synchronizer
    always_ff @(posedge clk) begin
        if (!resetn) begin
            data_sram_rdata <= 32'h0;
            led             <= RESET_LED;
            timer           <= 32'h0;
            scratch         <= 32'h0;
            sw_meta         <= 8'h0;
            sw_sync         <= 8'h0;
        end else begin
            if (data_sram_en)
                data_sram_rdata <= rd_val;
            timer   <= timer_wr ? (timer & ~mask) | (data_sram_wdata & mask) : timer + 32'd1;
            if (led_wr)
                led <= (led & ~mask[15:0]) | (data_sram_wdata[15:0] & mask[15:0]);
            if (scratch_wr)
                scratch <= (scratch & ~mask) | (data_sram_wdata & mask);
            sw_meta <= switch;
            sw_sync <= sw_meta;
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// tb_data_sram_responder: table-driven and directed checks of data_sram_responder
module tb_data_sram_responder;

    logic        clk;
    logic        resetn;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [15:0] led;
    logic [7:0]  sw;
    logic [31:0] timer_val;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        en;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp;
        logic [15:0] exp_led;
    } vec_t;

    localparam int NV = 29;
    vec_t v [NV];

    data_sram_responder dut (
        .clk            (clk),
        .resetn         (resetn),
        .data_sram_en   (en),
        .data_sram_we   (we),
        .data_sram_addr (addr),
        .data_sram_wdata(wdata),
        .data_sram_rdata(rdata),
        .led            (led),
        .switch         (sw),
        .timer_val      (timer_val)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        en    = e;
        we    = w;
        addr  = a;
        wdata = d;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        v[0]  = '{1'b1, 4'hF, 32'h1c000100, 32'hDEADBEEF, 1'b0, 32'h0,        16'h0};
        v[1]  = '{1'b1, 4'h0, 32'h1c000100, 32'h0,        1'b1, 32'hDEADBEEF, 16'h0};
        v[2]  = '{1'b1, 4'h5, 32'h1c000100, 32'h11223344, 1'b1, 32'hDEADBEEF, 16'h0};
        v[3]  = '{1'b1, 4'h0, 32'h1c000100, 32'h0,        1'b1, 32'hDE22BE44, 16'h0};
        v[4]  = '{1'b1, 4'hF, 32'h1c000200, 32'h0000AAAA, 1'b0, 32'h0,        16'h0};
        v[5]  = '{1'b1, 4'hF, 32'h1c000204, 32'h0000BBBB, 1'b0, 32'h0,        16'h0};
        v[6]  = '{1'b1, 4'hF, 32'h1c000208, 32'h0000CCCC, 1'b0, 32'h0,        16'h0};
        v[7]  = '{1'b1, 4'h0, 32'h1c000200, 32'h0,        1'b1, 32'h0000AAAA, 16'h0};
        v[8]  = '{1'b1, 4'h0, 32'h1c000204, 32'h0,        1'b1, 32'h0000BBBB, 16'h0};
        v[9]  = '{1'b1, 4'h0, 32'h1c000208, 32'h0,        1'b1, 32'h0000CCCC, 16'h0};
        v[10] = '{1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 32'h0000CCCC, 16'h0};
        v[11] = '{1'b0, 4'hF, 32'h1c000200, 32'hFFFFFFFF, 1'b1, 32'h0000CCCC, 16'h0};
        v[12] = '{1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 32'h0000CCCC, 16'h0};
        v[13] = '{1'b1, 4'h0, 32'h1c000200, 32'h0,        1'b1, 32'h0000AAAA, 16'h0};
        v[14] = '{1'b1, 4'h0, 32'h1c004100, 32'h0,        1'b1, 32'hDE22BE44, 16'h0};
        v[15] = '{1'b1, 4'hF, 32'h1c000004, 32'h55555555, 1'b0, 32'h0,        16'h0};
        v[16] = '{1'b1, 4'hF, 32'hbfaf0004, 32'hFFFFFFFF, 1'b1, 32'h0,        16'h0};
        v[17] = '{1'b1, 4'h0, 32'hbfaf0004, 32'h0,        1'b1, 32'h0,        16'h0};
        v[18] = '{1'b1, 4'h0, 32'h1c000004, 32'h0,        1'b1, 32'h55555555, 16'h0};
        v[19] = '{1'b1, 4'hF, 32'hbfaff000, 32'hABCD1234, 1'b1, 32'h0,        16'h1234};
        v[20] = '{1'b1, 4'h0, 32'hbfaff000, 32'h0,        1'b1, 32'h00001234, 16'h1234};
        v[21] = '{1'b1, 4'hC, 32'hbfaff000, 32'hFFFFFFFF, 1'b1, 32'h00001234, 16'h1234};
        v[22] = '{1'b1, 4'h0, 32'hbfaff000, 32'h0,        1'b1, 32'h00001234, 16'h1234};
        v[23] = '{1'b1, 4'h1, 32'hbfaff000, 32'h000000AB, 1'b1, 32'h00001234, 16'h12AB};
        v[24] = '{1'b1, 4'h0, 32'hbfaff000, 32'h0,        1'b1, 32'h000012AB, 16'h12AB};
        v[25] = '{1'b1, 4'hC, 32'hbfaff020, 32'h12345678, 1'b1, 32'h0,        16'h12AB};
        v[26] = '{1'b1, 4'h0, 32'hbfaff020, 32'h0,        1'b1, 32'h12340000, 16'h12AB};
        v[27] = '{1'b1, 4'h1, 32'hbfaff020, 32'h000000EE, 1'b1, 32'h12340000, 16'h12AB};
        v[28] = '{1'b1, 4'h0, 32'hbfaff020, 32'h0,        1'b1, 32'h123400EE, 16'h12AB};

        clk    = 1'b0;
        resetn = 1'b0;
        sw     = 8'h0;
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        tick;
        tick;
        check("reset rdata", rdata, 32'h0);
        check("reset led", {16'h0, led}, 32'h0);
        check("reset timer", timer_val, 32'h0);
        resetn = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(v[i].en, v[i].we, v[i].addr, v[i].wdata);
            tick;
            if (v[i].chk)
                check($sformatf("vec%0d rdata", i), rdata, v[i].exp);
            check($sformatf("vec%0d led", i), {16'h0, led}, {16'h0, v[i].exp_led});
        end

        drive(1'b1, 4'hF, 32'hbfafe000, 32'hFFFFFFFE);
        tick;
        check("timer load", timer_val, 32'hFFFFFFFE);
        drive(1'b1, 4'h0, 32'hbfafe000, 32'h0);
        tick;
        check("timer read1", rdata, 32'hFFFFFFFE);
        check("timer count", timer_val, 32'hFFFFFFFF);
        tick;
        check("timer read2", rdata, 32'hFFFFFFFF);
        check("timer wrap", timer_val, 32'h0);
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        tick;
        check("timer after wrap", timer_val, 32'h1);

        sw = 8'hA5;
        drive(1'b1, 4'h0, 32'hbfaff010, 32'h0);
        tick;
        check("switch edge1", rdata, 32'h0);
        tick;
        check("switch edge2", rdata, 32'h0);
        tick;
        check("switch edge3", rdata, 32'h000000A5);
        drive(1'b1, 4'hF, 32'hbfaff010, 32'h0);
        tick;
        check("switch write cycle", rdata, 32'h000000A5);
        drive(1'b1, 4'h0, 32'hbfaff010, 32'h0);
        tick;
        check("switch after write", rdata, 32'h000000A5);

        drive(1'b1, 4'h0, 32'h1c000100, 32'h0);
        tick;
        check("pre-reset load", rdata, 32'hDE22BE44);
        resetn = 1'b0;
        drive(1'b1, 4'hF, 32'h1c000100, 32'h0);
        tick;
        check("midreset rdata", rdata, 32'h0);
        check("midreset led", {16'h0, led}, 32'h0);
        check("midreset timer", timer_val, 32'h0);
        resetn = 1'b1;
        drive(1'b1, 4'h0, 32'h1c000100, 32'h0);
        tick;
        check("ram kept over reset", rdata, 32'hDE22BE44);
        check("timer restart", timer_val, 32'h1);
        drive(1'b1, 4'h0, 32'hbfaf0004, 32'h0);
        tick;
        check("unmapped after reset", rdata, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
